// File: rtl/llr_seq_pkg.sv
// ---------------------------------------------------------------------------
// llr_seq_pkg : state encoding and per-code geometry for llr_seq_ctrl
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package llr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_READ = 3'd2,
    ST_ROT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] CODE_64      = 2'd0;
  localparam logic [1:0] CODE_256     = 2'd1;
  localparam logic [1:0] CODE_1024    = 2'd2;
  localparam logic [1:0] CODE_ILLEGAL = 2'd3;

  localparam int POS_W  = 7;
  localparam int WORD_W = 64;

  function automatic logic [7:0] code_words(input logic [1:0] code);
    case (code)
      CODE_64:   code_words = 8'd8;
      CODE_256:  code_words = 8'd32;
      CODE_1024: code_words = 8'd128;
      default:   code_words = 8'd0;
    endcase
  endfunction

  function automatic logic [3:0] code_segs(input logic [1:0] code);
    case (code)
      CODE_64:   code_segs = 4'd1;
      CODE_256:  code_segs = 4'd2;
      CODE_1024: code_segs = 4'd8;
      default:   code_segs = 4'd0;
    endcase
  endfunction

  function automatic logic [5:0] code_groups(input logic [1:0] code);
    case (code)
      CODE_64:   code_groups = 6'd16;
      CODE_256:  code_groups = 6'd32;
      CODE_1024: code_groups = 6'd32;
      default:   code_groups = 6'd0;
    endcase
  endfunction

  function automatic logic code_rot_en(input logic [1:0] code);
    code_rot_en = (code == CODE_256) || (code == CODE_1024);
  endfunction

endpackage

`default_nettype wire

// File: rtl/llr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// llr_seq_ctrl : loads an LLR frame into the shift buffer, then walks it in
//                128-entry segments with 4 read positions per cycle.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module llr_seq_ctrl
  import llr_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_code,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_data,
  input  logic        i_hold,
  output logic        o_mem_wen,
  output logic [63:0] o_mem_data,
  output logic        o_mem_rot,
  output logic [1:0]  o_mem_code,
  output logic [6:0]  o_pos0,
  output logic [6:0]  o_pos1,
  output logic [6:0]  o_pos2,
  output logic [6:0]  o_pos3,
  output logic        o_rd_valid,
  output logic        o_rd_last,
  output logic [2:0]  o_seg_idx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  state_e      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [6:0]  word_q, word_d;
  logic [4:0]  grp_q, grp_d;
  logic [2:0]  seg_q, seg_d;
  logic        rd_valid_q, rd_last_q;
  logic [2:0]  rd_seg_q;

  logic w_ready, w_rot, w_issue, w_done, w_err;
  logic w_word_last, w_grp_last, w_seg_last;

  assign w_word_last = ({1'b0, word_q} == (code_words(code_q) - 8'd1));
  assign w_grp_last  = ({1'b0, grp_q} == (code_groups(code_q) - 6'd1));
  assign w_seg_last  = ({1'b0, seg_q} == (code_segs(code_q) - 4'd1));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    word_d  = word_q;
    grp_d   = grp_q;
    seg_d   = seg_q;
    w_ready = 1'b0;
    w_rot   = 1'b0;
    w_issue = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_code == CODE_ILLEGAL) begin
            w_err = 1'b1;
          end else begin
            code_d  = i_code;
            word_d  = 7'd0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        grp_d   = 5'd0;
        seg_d   = 3'd0;
        if (i_in_valid) begin
          word_d = word_q + 7'd1;
          if (w_word_last) begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (!i_hold) begin
          w_issue = 1'b1;
          grp_d   = grp_q + 5'd1;
          if (w_grp_last) begin
            grp_d   = 5'd0;
            state_d = code_rot_en(code_q) ? ST_ROT : ST_DONE;
          end
        end
      end
      ST_ROT: begin
        // The last rotation is kept on purpose: it returns the buffer to load order.
        if (!i_hold) begin
          w_rot = 1'b1;
          if (w_seg_last) begin
            state_d = ST_DONE;
          end else begin
            seg_d   = seg_q + 3'd1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        w_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      code_q     <= 2'd0;
      word_q     <= 7'd0;
      grp_q      <= 5'd0;
      seg_q      <= 3'd0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_seg_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      word_q     <= word_d;
      grp_q      <= grp_d;
      seg_q      <= seg_d;
      rd_valid_q <= w_issue;
      rd_last_q  <= w_issue & w_grp_last;
      if (w_issue) begin
        rd_seg_q <= seg_q;
      end
    end
  end

  // Reset gates every control output so no strobe escapes in the reset cycle.
  logic w_in_read;
  assign w_in_read = (state_q == ST_READ) && !i_rst;

  assign o_in_ready = w_ready & ~i_rst;
  assign o_mem_wen  = w_ready & i_in_valid & ~i_rst;
  assign o_mem_data = i_in_data;
  assign o_mem_rot  = w_rot & ~i_rst;
  assign o_mem_code = i_rst ? 2'd0 : code_q;
  assign o_pos0     = w_in_read ? {grp_q, 2'd0} : 7'd0;
  assign o_pos1     = w_in_read ? {grp_q, 2'd1} : 7'd0;
  assign o_pos2     = w_in_read ? {grp_q, 2'd2} : 7'd0;
  assign o_pos3     = w_in_read ? {grp_q, 2'd3} : 7'd0;
  assign o_rd_valid = rd_valid_q & ~i_rst;
  assign o_rd_last  = rd_last_q & ~i_rst;
  assign o_seg_idx  = i_rst ? 3'd0 : rd_seg_q;
  assign o_busy     = (state_q != ST_IDLE) && !i_rst;
  assign o_done     = w_done & ~i_rst;
  assign o_err      = w_err & ~i_rst;

endmodule

`default_nettype wire

// File: tb/tb_llr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_llr_seq_ctrl : scenario table plus randomized frames against an
//                   action-queue reference model of llr_seq_ctrl.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_llr_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_in_valid, i_hold;
  logic [1:0]  i_code;
  logic [63:0] i_in_data;
  logic        o_in_ready, o_mem_wen, o_mem_rot, o_rd_valid, o_rd_last;
  logic        o_busy, o_done, o_err;
  logic [63:0] o_mem_data;
  logic [1:0]  o_mem_code;
  logic [6:0]  o_pos0, o_pos1, o_pos2, o_pos3;
  logic [2:0]  o_seg_idx;

  always #5 i_clk = ~i_clk;

  llr_seq_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_code(i_code),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .i_hold(i_hold), .o_mem_wen(o_mem_wen), .o_mem_data(o_mem_data),
    .o_mem_rot(o_mem_rot), .o_mem_code(o_mem_code),
    .o_pos0(o_pos0), .o_pos1(o_pos1), .o_pos2(o_pos2), .o_pos3(o_pos3),
    .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last), .o_seg_idx(o_seg_idx),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model: a frame is words to accept followed by a list of actions
  // (issue a group, or rotate), each consuming one non-held cycle, then done.
  typedef struct packed {
    logic       rot;
    logic       last;
    logic [2:0] seg;
    logic [4:0] grp;
  } act_t;

  act_t       q[$];
  int         words_left;
  bit         done_pend;
  logic [1:0] m_code;
  bit         p_iss, p_last;
  logic [2:0] p_seg;

  function automatic int tb_words(input logic [1:0] c);
    return (c == 2'd0) ? 8 : (c == 2'd1) ? 32 : 128;
  endfunction
  function automatic int tb_segs(input logic [1:0] c);
    return (c == 2'd0) ? 1 : (c == 2'd1) ? 2 : 8;
  endfunction
  function automatic int tb_groups(input logic [1:0] c);
    return (c == 2'd0) ? 16 : 32;
  endfunction

  task automatic model_reset();
    words_left = 0; q.delete(); done_pend = 0; m_code = 2'd0;
    p_iss = 0; p_last = 0; p_seg = 3'd0;
  endtask

  task automatic model_step();
    bit   iss;
    act_t a;
    if (i_rst) begin
      model_reset();
    end else begin
      iss = (words_left == 0) && (q.size() > 0) && !q[0].rot && !i_hold;
      if (iss) begin p_last = q[0].last; p_seg = q[0].seg; end
      p_iss = iss;
      if (words_left > 0) begin
        if (i_in_valid) words_left--;
      end else if (q.size() > 0) begin
        if (!i_hold) void'(q.pop_front());
      end else if (done_pend) begin
        done_pend = 0;
      end else if (i_start && i_code != 2'd3) begin
        m_code = i_code;
        words_left = tb_words(i_code);
        done_pend = 1;
        for (int s = 0; s < tb_segs(i_code); s++) begin
          for (int g = 0; g < tb_groups(i_code); g++) begin
            a.rot = 1'b0; a.seg = 3'(s); a.grp = 5'(g);
            a.last = (g == tb_groups(i_code) - 1);
            q.push_back(a);
          end
          if (i_code != 2'd0) begin
            a.rot = 1'b1; a.last = 1'b0; a.seg = 3'(s); a.grp = 5'd0;
            q.push_back(a);
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic e_rdy, e_wen, e_rot, e_v, e_l, e_busy, e_done, e_err;
    logic [6:0] e_p0, e_p1, e_p2, e_p3;
    logic [2:0] e_s, a_s;
    logic [1:0] e_c, a_c;
    logic [104:0] e, a;
    int base;
    {e_rdy, e_wen, e_rot, e_done, e_err} = '0;
    {e_p0, e_p1, e_p2, e_p3} = '0;
    e_busy = !i_rst && (words_left > 0 || q.size() > 0 || done_pend);
    e_v = !i_rst && p_iss;
    e_l = e_v && p_last;
    e_s = e_v ? p_seg : 3'd0;
    e_c = e_busy ? m_code : 2'd0;
    if (!i_rst) begin
      if (words_left > 0) begin
        e_rdy = 1'b1; e_wen = i_in_valid;
      end else if (q.size() > 0) begin
        if (q[0].rot) e_rot = !i_hold;
        else begin
          base = 4 * int'(q[0].grp);
          e_p0 = 7'(base); e_p1 = 7'(base + 1); e_p2 = 7'(base + 2); e_p3 = 7'(base + 3);
        end
      end else if (done_pend) begin
        e_done = 1'b1;
      end else begin
        e_err = i_start && (i_code == 2'd3);
      end
    end
    a_s = e_v ? o_seg_idx : 3'd0;
    a_c = e_busy ? o_mem_code : 2'd0;
    e = {e_rdy, e_wen, e_rot, e_p0, e_p1, e_p2, e_p3, e_v, e_l, e_s, e_busy, e_done, e_err, e_c, i_in_data};
    a = {o_in_ready, o_mem_wen, o_mem_rot, o_pos0, o_pos1, o_pos2, o_pos3, o_rd_valid, o_rd_last,
         a_s, o_busy, o_done, o_err, a_c, o_mem_data};
    n_vec++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL cycle %0d outputs: got %h expected %h", cyc, a, e);
    end
  endtask

  // Per-frame observations of the DUT
  int          n_wen, n_val, n_rot, first_wen, last_wen, done_cyc;
  bit          seen_done, seg3_seen;
  logic [63:0] buf_q[$];
  logic [63:0] loaded[$];

  task automatic clear_stats();
    n_wen = 0; n_val = 0; n_rot = 0; first_wen = -1; last_wen = -1; done_cyc = -1;
    seen_done = 0; seg3_seen = 0; buf_q.delete(); loaded.delete();
  endtask

  task automatic tick();
    @(negedge i_clk);
    check_outputs();
    if (o_mem_wen) begin
      n_wen++;
      if (first_wen < 0) first_wen = cyc;
      last_wen = cyc;
      buf_q.push_back(o_mem_data);
      loaded.push_back(o_mem_data);
    end
    if (o_mem_rot) begin
      n_rot++;
      for (int k = 0; k < 16; k++) if (buf_q.size() > 0) buf_q.push_back(buf_q.pop_front());
    end
    if (o_rd_valid) begin
      n_val++;
      if (o_seg_idx == 3'd3) seg3_seen = 1;
    end
    if (o_done) begin seen_done = 1; done_cyc = cyc; end
    @(posedge i_clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] code;
    int vpct, hpct;
    bit noise, toggle, hmode;
    int ewen, eval, erot, elat, espan;
  } scen_t;

  task automatic run_frame(input scen_t s);
    bit tog, hg, hr, ok;
    int hleft;
    clear_stats();
    i_start = 1'b1; i_code = s.code; i_in_valid = 1'b0; i_hold = 1'b0;
    tick();
    i_start = 1'b0;
    tog = 1; hg = 0; hr = 0; hleft = 0;
    for (int n = 0; n < 3000 && !seen_done; n++) begin
      i_in_valid = s.toggle ? tog : ($urandom_range(99) < s.vpct);
      tog = !tog;
      if (s.hmode) begin
        if (hleft == 0 && words_left == 0 && q.size() > 0) begin
          if (!hg && !q[0].rot && q[0].seg == 3'd1 && q[0].grp == 5'd10) begin hg = 1; hleft = 3; end
          else if (!hr && q[0].rot) begin hr = 1; hleft = 3; end
        end
        i_hold = (hleft > 0);
        if (hleft > 0) hleft--;
      end else begin
        i_hold = ($urandom_range(99) < s.hpct);
      end
      i_start   = s.noise ? 1'($urandom_range(1)) : 1'b0;
      i_code    = 2'($urandom);
      i_in_data = {$urandom, $urandom};
      tick();
    end
    i_start = 1'b0; i_in_valid = 1'b0; i_hold = 1'b0;
    cmp("done_seen", int'(seen_done), 1);
    cmp("wen_count", n_wen, s.ewen);
    cmp("valid_count", n_val, s.eval);
    cmp("rot_count", n_rot, s.erot);
    if (s.elat >= 0) cmp("latency", done_cyc - first_wen + 1, s.elat);
    if (s.espan >= 0) cmp("load_span", last_wen - first_wen + 1, s.espan);
    ok = (buf_q.size() == loaded.size());
    for (int k = 0; k < buf_q.size() && ok; k++) if (buf_q[k] !== loaded[k]) ok = 0;
    cmp("buffer_order", int'(ok), 1);
    if (!seen_done) begin
      i_rst = 1'b1; tick(); i_rst = 1'b0;
    end
    tick();
  endtask

  scen_t tbl[8];
  scen_t r;

  initial begin
    //            code  v%  h%  nz tg hm  wen  val rot  lat  span
    tbl[0] = '{2'd0, 100, 0, 1'b0, 1'b0, 1'b0,   8,  16, 0,  25,   8};
    tbl[1] = '{2'd1, 100, 0, 1'b0, 1'b0, 1'b0,  32,  64, 2,  99,  32};
    tbl[2] = '{2'd2, 100, 0, 1'b0, 1'b0, 1'b0, 128, 256, 8, 393, 128};
    tbl[3] = '{2'd1, 100, 0, 1'b0, 1'b1, 1'b0,  32,  64, 2, 130,  63};
    tbl[4] = '{2'd1, 100, 0, 1'b1, 1'b0, 1'b1,  32,  64, 2, 105,  32};
    tbl[5] = '{2'd0,  60, 30, 1'b1, 1'b0, 1'b0,  8,  16, 0,  -1,  -1};
    tbl[6] = '{2'd2,  70, 20, 1'b1, 1'b0, 1'b0, 128, 256, 8, -1,  -1};
    tbl[7] = '{2'd1,  50, 50, 1'b1, 1'b0, 1'b0,  32,  64, 2,  -1,  -1};

    i_rst = 1'b1; i_start = 1'b0; i_code = 2'd0; i_in_valid = 1'b0;
    i_hold = 1'b0; i_in_data = 64'd0;
    model_reset();
    clear_stats();
    tick(); tick();
    i_rst = 1'b0;
    tick();

    // Illegal code: error pulse, stays idle
    i_start = 1'b1; i_code = 2'd3;
    tick();
    i_start = 1'b0;
    tick();

    for (int t = 0; t < 8; t++) run_frame(tbl[t]);

    for (int t = 0; t < 6; t++) begin
      r.code = 2'($urandom_range(2));
      r.vpct = $urandom_range(90, 30); r.hpct = $urandom_range(50);
      r.noise = 1'b1; r.toggle = 1'b0; r.hmode = 1'b0;
      r.ewen = tb_words(r.code);
      r.eval = tb_segs(r.code) * tb_groups(r.code);
      r.erot = (r.code == 2'd0) ? 0 : tb_segs(r.code);
      r.elat = -1; r.espan = -1;
      run_frame(r);
    end

    // Reset in segment 3 of a 1024 frame, with start asserted alongside
    clear_stats();
    i_start = 1'b1; i_code = 2'd2;
    tick();
    i_start = 1'b0; i_in_valid = 1'b1;
    for (int n = 0; n < 1000 && !seg3_seen; n++) begin
      i_in_data = {$urandom, $urandom};
      tick();
    end
    cmp("seg3_reached", int'(seg3_seen), 1);
    i_rst = 1'b1; i_start = 1'b1; i_code = 2'd0;
    tick();
    i_rst = 1'b0; i_start = 1'b0; i_in_valid = 1'b0;
    tick();
    run_frame(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
